phase_sequencer: RTL and testbench

//  Downstream consumer of the four-phase timing scheme: generates four one-hot

---
 rtl/phase_sequencer_if.sv | 23 ++
 rtl/phase_sequencer.sv | 111 +++++++++++
 tb/tb_phase_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/phase_sequencer_if.sv
// Control and status bundle of the four-phase sequencer.
// master drives run/step/cnt_clr; slave (the sequencer) returns the phase enables and status.
interface phase_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic             run;
    logic             step;
    logic             cnt_clr;
    logic [3:0]       ph;
    logic             ph_last;
    logic             busy;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output run, step, cnt_clr,
        input  ph, ph_last, busy, cycle_count
    );

    modport slave (
        input  run, step, cnt_clr,
        output ph, ph_last, busy, cycle_count
    );
endinterface

// File: rtl/phase_sequencer.sv
// Four-phase one-hot clock-enable generator with run/halt, per-phase stretch and cycle counter.
// Optional single-step start in IDLE is enabled by defining PHASE_SEQ_STEP_EN.
module phase_sequencer #(
    parameter int unsigned DIV   = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic                clock,
    input  logic                resetn,
    phase_sequencer_if.slave    bus
);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       ph_q, ph_d;
    logic             ph_last_q, ph_last_d;
    logic             busy_q, busy_d;
    logic             start_c;
    logic             cycle_end_c;

    // A new 4-phase cycle may only be launched from IDLE.
`ifdef PHASE_SEQ_STEP_EN
    assign start_c = bus.run | bus.step;
`else
    logic unused_step_c;
    assign unused_step_c = bus.step;
    assign start_c       = bus.run;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            phase_q   <= 2'd0;
            div_cnt_q <= '0;
            count_q   <= '0;
            ph_q      <= 4'b0000;
            ph_last_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            div_cnt_q <= div_cnt_d;
            count_q   <= count_d;
            ph_q      <= ph_d;
            ph_last_q <= ph_last_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        div_cnt_d   = div_cnt_q;
        count_d     = count_q;
        cycle_end_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_c) begin
                    state_d   = RUN;
                    phase_d   = 2'd0;
                    div_cnt_d = '0;
                end
            end
            RUN: begin
                if (div_cnt_q == DIV_MAX) begin
                    div_cnt_d = '0;
                    if (phase_q == 2'd3) begin
                        // Cycle boundary: run is only honoured here, never mid-cycle.
                        cycle_end_c = 1'b1;
                        phase_d     = 2'd0;
                        if (!bus.run) begin
                            state_d = IDLE;
                        end
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.cnt_clr) begin
            count_d = '0;
        end else if (cycle_end_c) begin
            count_d = count_q + CNT_W'(1);
        end

        // Outputs are decoded from the next state so they line up with it after the edge.
        ph_d      = (state_d == RUN) ? (4'b0001 << phase_d) : 4'b0000;
        busy_d    = (state_d == RUN);
        ph_last_d = (state_d == RUN) && (phase_d == 2'd3) && (div_cnt_d == DIV_MAX);
    end

    assign bus.ph          = ph_q;
    assign bus.ph_last     = ph_last_q;
    assign bus.busy        = busy_q;
    assign bus.cycle_count = count_q;
endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: two instances (DIV=1/CNT_W=4, DIV=3/CNT_W=16)
// share stimulus; a position-in-cycle reference model feeds queues drained by a monitor.
module tb_phase_sequencer;
    localparam int unsigned D1 = 1;
    localparam int unsigned W1 = 4;
    localparam int unsigned D3 = 3;
    localparam int unsigned W3 = 16;

    typedef struct {
        logic [3:0]  ph;
        logic        last;
        logic        busy;
        int unsigned cnt;
    } exp_t;

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    phase_sequencer_if #(.CNT_W(W1)) bus1 ();
    phase_sequencer_if #(.CNT_W(W3)) bus3 ();

    phase_sequencer #(.DIV(D1), .CNT_W(W1)) u_dut1 (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus1.slave)
    );

    phase_sequencer #(.DIV(D3), .CNT_W(W3)) u_dut3 (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus3.slave)
    );

    int total = 0;
    int bad   = 0;
    exp_t q1[$];
    exp_t q3[$];

    // Model state: active flag, clock position within the 4*DIV-clock cycle, completed cycles.
    bit          act1, act3;
    int unsigned pos1, pos3, cnt1, cnt3;

    task automatic check(input string name, input int unsigned got, input int unsigned want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_step(input int unsigned div, input int unsigned w,
                              input logic r, input logic s, input logic c,
                              inout bit act, inout int unsigned pos, inout int unsigned cnt,
                              output exp_t e);
        bit start;
        bit wrapped;
        start = r;
`ifdef PHASE_SEQ_STEP_EN
        start = r | s;
`endif
        wrapped = 1'b0;
        if (!act) begin
            if (start) begin
                act = 1'b1;
                pos = 0;
            end
        end else if (pos == 4 * div - 1) begin
            wrapped = 1'b1;
            if (r) pos = 0;
            else   act = 1'b0;
        end else begin
            pos++;
        end
        if (c)            cnt = 0;
        else if (wrapped) cnt = (cnt + 1) % (32'd1 << w);
        e.ph   = act ? 4'(32'd1 << (pos / div)) : 4'b0000;
        e.last = act && (pos == 4 * div - 1);
        e.busy = act;
        e.cnt  = cnt;
    endtask

    function automatic exp_t zero_exp();
        exp_t e;
        e.ph = 4'b0000; e.last = 1'b0; e.busy = 1'b0; e.cnt = 0;
        return e;
    endfunction

    task automatic model_reset();
        act1 = 1'b0; pos1 = 0; cnt1 = 0;
        act3 = 1'b0; pos3 = 0; cnt3 = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ph1"},   32'(bus1.ph), 0);
        check({tag, "_busy1"}, 32'(bus1.busy), 0);
        check({tag, "_cnt1"},  32'(bus1.cycle_count), 0);
        check({tag, "_ph3"},   32'(bus3.ph), 0);
        check({tag, "_last3"}, 32'(bus3.ph_last), 0);
        check({tag, "_busy3"}, 32'(bus3.busy), 0);
        check({tag, "_cnt3"},  32'(bus3.cycle_count), 0);
    endtask

    // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
    task automatic drive(input logic r, input logic s, input logic c, input bit rst_mid = 1'b0);
        exp_t e1, e3;
        @(negedge clock);
        resetn       = 1'b1;
        bus1.run     = r; bus1.step = s; bus1.cnt_clr = c;
        bus3.run     = r; bus3.step = s; bus3.cnt_clr = c;
        if (rst_mid) begin
            #2 resetn = 1'b0;
            #1 check_zero("async_rst");
        end
        @(posedge clock);
        if (!resetn) begin
            model_reset();
            q1.push_back(zero_exp());
            q3.push_back(zero_exp());
        end else begin
            model_step(D1, W1, r, s, c, act1, pos1, cnt1, e1);
            model_step(D3, W3, r, s, c, act3, pos3, cnt3, e3);
            q1.push_back(e1);
            q3.push_back(e3);
        end
    endtask

    // Monitor: compares every registered output shortly after each active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("ph_d1",   32'(bus1.ph), 32'(e.ph));
                check("last_d1", 32'(bus1.ph_last), 32'(e.last));
                check("busy_d1", 32'(bus1.busy), 32'(e.busy));
                check("cnt_d1",  32'(bus1.cycle_count), e.cnt);
            end
            if (q3.size() > 0) begin
                e = q3.pop_front();
                check("ph_d3",   32'(bus3.ph), 32'(e.ph));
                check("last_d3", 32'(bus3.ph_last), 32'(e.last));
                check("busy_d3", 32'(bus3.busy), 32'(e.busy));
                check("cnt_d3",  32'(bus3.cycle_count), e.cnt);
            end
        end
    end

    initial begin
        bit clr_done;
        int n;
        resetn = 1'b0;
        bus1.run = 1'b0; bus1.step = 1'b0; bus1.cnt_clr = 1'b0;
        bus3.run = 1'b0; bus3.step = 1'b0; bus3.cnt_clr = 1'b0;
        model_reset();
        #3 check_zero("reset");
        @(negedge clock);
        @(negedge clock);

        repeat (2) drive(1'b0, 1'b0, 1'b0);

        // Long run: DIV=1 instance wraps its 4-bit counter; one cnt_clr lands on ph_last.
        clr_done = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (!clr_done && i >= 70 && act1 && pos1 == 3) begin
                clr_done = 1'b1;
                drive(1'b1, 1'b0, 1'b1);
            end else begin
                drive(1'b1, 1'b0, 1'b0);
            end
        end
        check("clr_on_last_hit", 32'(clr_done), 1);

        // Drop run while the DIV=3 instance is in phase 1; the cycle must still finish.
        n = 0;
        while (!(act3 && pos3 / D3 == 1) && n < 20) begin
            drive(1'b1, 1'b0, 1'b0);
            n++;
        end
        check("reach_phase1", 32'(n < 20), 1);
        repeat (15) drive(1'b0, 1'b0, 1'b0);

        // Asynchronous reset while the DIV=3 instance is in phase 2, then restart.
        n = 0;
        while (!(act3 && pos3 / D3 == 2) && n < 20) begin
            drive(1'b1, 1'b0, 1'b0);
            n++;
        end
        check("reach_phase2", 32'(n < 20), 1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (8) drive(1'b1, 1'b0, 1'b0);
        repeat (14) drive(1'b0, 1'b0, 1'b0);

        // Step pulse from IDLE, a second pulse while busy, then let it settle.
        drive(1'b0, 1'b1, 1'b0);
        repeat (2) drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        repeat (16) drive(1'b0, 1'b0, 1'b0);

        // Randomized mix of run, step and cnt_clr.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 32) == 0);
        end
        repeat (20) drive(1'b0, ($urandom % 6) == 0, 1'b0);

        @(negedge clock);
        @(negedge clock);
        check("scoreboard_drained", 32'(q1.size() + q3.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
